// File: rtl/sram16_pkg.sv
// Shared constants and types for the sram16 banked-row memory and its
// fill/fetch sequencers.
package sram16_pkg;

  localparam int NUM_BANKS  = 16;
  localparam int BEAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    LAST    = 2'd2,
    DONE    = 2'd3
  } loader_state_t;

endpackage

// File: rtl/sram16_row_loader.sv
// Packs 16 narrow stream beats into a full sram16 row and writes rows through
// the wrapper load port at incrementing (wrapping) addresses from a base.
module sram16_row_loader
  import sram16_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [ADDR_WIDTH:0]             num_rows,
  output logic                            busy,
  output logic                            done,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            load_en,
  output logic [ADDR_WIDTH-1:0]           load_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] load_data
);

  typedef logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] row_t;

  loader_state_t           state_q, state_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH:0]     row_cnt_q, row_cnt_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH:0]     num_rows_q, num_rows_d;
  row_t                    row_buf_q, row_buf_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    load_en_q, load_en_d;
  logic [ADDR_WIDTH-1:0]   load_addr_q, load_addr_d;
  row_t                    load_data_q, load_data_d;
  logic                    accept;

  assign in_ready  = (state_q == COLLECT);
  assign accept    = in_ready && in_valid;
  assign busy      = busy_q;
  assign done      = done_q;
  assign load_en   = load_en_q;
  assign load_addr = load_addr_q;
  assign load_data = load_data_q;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    row_cnt_d   = row_cnt_q;
    base_d      = base_q;
    num_rows_d  = num_rows_q;
    row_buf_d   = row_buf_q;
    load_en_d   = 1'b0;
    load_addr_d = load_addr_q;
    load_data_d = load_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_rows != '0) begin
            base_d     = base_addr;
            num_rows_d = num_rows;
            beat_cnt_d = '0;
            row_cnt_d  = '0;
            state_d    = COLLECT;
          end else begin
            state_d = DONE;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          row_buf_d[beat_cnt_q] = in_data;
          beat_cnt_d            = beat_cnt_q + 1'b1;
          if (beat_cnt_q == BEAT_CNT_W'(NUM_BANKS - 1)) begin
            // Row goes to its own output register so the next row can start
            // filling row_buf on the very next cycle.
            load_en_d   = 1'b1;
            load_addr_d = base_q + row_cnt_q[ADDR_WIDTH-1:0];
            load_data_d = row_buf_d;
            row_cnt_d   = row_cnt_q + 1'b1;
            if (row_cnt_q == num_rows_q - (ADDR_WIDTH+1)'(1))
              state_d = LAST;
          end
        end
      end
      LAST:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      row_cnt_q   <= '0;
      base_q      <= '0;
      num_rows_q  <= '0;
      row_buf_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_en_q   <= 1'b0;
      load_addr_q <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      row_cnt_q   <= row_cnt_d;
      base_q      <= base_d;
      num_rows_q  <= num_rows_d;
      row_buf_q   <= row_buf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      load_en_q   <= load_en_d;
      load_addr_q <= load_addr_d;
      load_data_q <= load_data_d;
    end
  end

endmodule
